// File: rtl/traffic_pkg.sv
// Shared lamp encodings and phase states for the
// intersection phase scheduler.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2
  } phase_t;

endpackage

// File: rtl/intersection_phase_scheduler_tick_gen.sv
// Prescaler producing a one-cycle tick every
// TICK_DIV clock cycles.
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] L_LAST =
    CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == L_LAST);
  assign tick   = w_last;

  // count 0..TICK_DIV-1, wrap on the tick cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Round-robin phase sequencer for an N-leg junction:
// one green at a time, with min/max green, yellow, all-red.
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int N_APPROACH  = 4,
  parameter int TICK_DIV    = 4,
  parameter int T_MIN_GREEN = 5,
  parameter int T_MAX_GREEN = 10,
  parameter int T_YELLOW    = 3,
  parameter int T_ALL_RED   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_APPROACH-1:0]         req,
  output logic [3*N_APPROACH-1:0]       light,
  output logic [$clog2(N_APPROACH)-1:0] grant_idx,
  output logic                          grant_valid,
  output logic [N_APPROACH-1:0]         pend
);

  localparam int N  = N_APPROACH;
  localparam int CW = $clog2(N_APPROACH);
  localparam int TW = $clog2(T_MAX_GREEN + 1);

  localparam logic [TW:0] L_MING = (TW+1)'(T_MIN_GREEN);
  localparam logic [TW:0] L_MAXG = (TW+1)'(T_MAX_GREEN);
  localparam logic [TW:0] L_YEL  = (TW+1)'(T_YELLOW);
  localparam logic [TW:0] L_AR   = (TW+1)'(T_ALL_RED);
  localparam logic [TW-1:0] L_TSAT = TW'(T_MAX_GREEN);

  localparam logic [N-1:0] L_ONE = N'(1);

  phase_t          r_state;
  phase_t          w_state_nxt;
  logic [CW-1:0]   r_cur;
  logic [CW-1:0]   w_cur_nxt;
  logic [CW-1:0]   w_winner;
  logic [TW-1:0]   r_timer;
  logic [TW:0]     w_elapsed;
  logic [N-1:0]    r_pend;
  logic [N-1:0]    w_pend_nxt;
  logic [N-1:0]    w_cur_oh;
  logic [N-1:0]    w_win_oh;
  logic [N-1:0]    w_set;
  logic            w_other;
  logic            w_enter_green;
  logic            w_tick;
  logic [3*N-1:0]  r_light;
  logic [3*N-1:0]  w_light_nxt;
  logic            r_gvalid;

  // first pending approach after c, wrapping through c
  function automatic logic [CW-1:0] rr_pick(
    input logic [N-1:0]  p,
    input logic [CW-1:0] c
  );
    logic [CW-1:0] w;
    logic          found;
    int            idx;
    w     = c;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(c) + k) % N;
      if (!found && p[idx]) begin
        w     = CW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (w_tick)
  );

  assign w_elapsed = {1'b0, r_timer} + 1'b1;
  assign w_cur_oh  = L_ONE << r_cur;
  assign w_winner  = rr_pick(r_pend, r_cur);
  assign w_win_oh  = L_ONE << w_winner;
  assign w_other   = |(r_pend & ~w_cur_oh);

  // phase transitions, all gated by the tick
  always_comb begin
    w_state_nxt   = r_state;
    w_cur_nxt     = r_cur;
    w_enter_green = 1'b0;
    case (r_state)
      ALL_RED: begin
        if (w_tick && w_elapsed == L_AR) begin
          w_state_nxt   = GREEN;
          w_cur_nxt     = w_winner;
          w_enter_green = 1'b1;
        end
      end
      GREEN: begin
        if (w_tick && w_other &&
            (w_elapsed >= L_MAXG ||
             (w_elapsed >= L_MING && !req[r_cur]))) begin
          w_state_nxt = YELLOW;
        end
      end
      YELLOW: begin
        if (w_tick && w_elapsed == L_YEL) begin
          w_state_nxt = ALL_RED;
        end
      end
      default: begin
        w_state_nxt = ALL_RED;
      end
    endcase
  end

  // request latch: the green approach does not re-latch,
  // and the winner's clear beats a same-cycle set
  always_comb begin
    w_set = req;
    if (r_state == GREEN) begin
      w_set = req & ~w_cur_oh;
    end
    w_pend_nxt = r_pend | w_set;
    if (w_enter_green) begin
      w_pend_nxt = w_pend_nxt & ~w_win_oh;
    end
  end

  // lamp pattern for the upcoming state and approach
  always_comb begin
    w_light_nxt = {N{LIGHT_RED}};
    for (int i = 0; i < N; i++) begin
      if (CW'(i) == w_cur_nxt) begin
        if (w_state_nxt == GREEN) begin
          w_light_nxt[3*i +: 3] = LIGHT_GRN;
        end else if (w_state_nxt == YELLOW) begin
          w_light_nxt[3*i +: 3] = LIGHT_YEL;
        end
      end
    end
  end

  // state, approach, pending and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ALL_RED;
      r_cur    <= '0;
      r_pend   <= '0;
      r_light  <= {N{LIGHT_RED}};
      r_gvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cur    <= w_cur_nxt;
      r_pend   <= w_pend_nxt;
      r_light  <= w_light_nxt;
      r_gvalid <= (w_state_nxt == GREEN);
    end
  end

  // ticks spent in the current state, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (w_state_nxt != r_state) begin
      r_timer <= '0;
    end else if (w_tick && r_timer != L_TSAT) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign light       = r_light;
  assign grant_idx   = r_cur;
  assign grant_valid = r_gvalid;
  assign pend        = r_pend;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler
// with default timing parameters.
module tb_intersection_phase_scheduler;

  localparam logic [11:0] L_RED = 12'h924;
  localparam logic [11:0] L_G0  = 12'h921;
  localparam logic [11:0] L_Y0  = 12'h922;
  localparam logic [11:0] L_G1  = 12'h90C;
  localparam logic [11:0] L_Y1  = 12'h914;
  localparam logic [11:0] L_G2  = 12'h864;
  localparam logic [11:0] L_Y2  = 12'h8A4;
  localparam logic [11:0] L_G3  = 12'h324;
  localparam logic [11:0] L_Y3  = 12'h524;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] light;
  logic [1:0]  grant_idx;
  logic        grant_valid;
  logic [3:0]  pend;

  int n_pass;
  int n_total;
  int ecnt;

  intersection_phase_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .light      (light),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .pend       (pend)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int nonred(input logic [11:0] l);
    int c;
    c = 0;
    for (int i = 0; i < 4; i++) begin
      if (l[3*i +: 3] != 3'b100) c++;
    end
    return c;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      assert (nonred(light) <= 1)
        else $error("FAIL one_green light=%h", light);
    end
  end

  task automatic run_to(input int e);
    while (ecnt < e) begin
      @(posedge clk);
      ecnt++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ecnt  = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    if (light !== L_RED)
      $display("FAIL rst_light got %h want %h",
               light, L_RED);
    else n_pass++;
    n_total++;
    if (grant_valid !== 1'b0)
      $display("FAIL rst_gv got %b want 0", grant_valid);
    else n_pass++;
    n_total++;
    if (pend !== 4'b0)
      $display("FAIL rst_pend got %b want 0", pend);
    else n_pass++;
    n_total++;
    run_to(3);
    if (light !== L_RED)
      $display("FAIL idle_c3 got %h want %h",
               light, L_RED);
    else n_pass++;
    n_total++;
    run_to(4);
    if (light !== L_G0 || grant_valid !== 1'b1)
      $display("FAIL idle_c4 got %h/%b want %h/1",
               light, grant_valid, L_G0);
    else n_pass++;
    n_total++;
    if (grant_idx !== 2'd0)
      $display("FAIL idle_idx got %0d want 0", grant_idx);
    else n_pass++;
    n_total++;
    run_to(100);
    if (light !== L_G0)
      $display("FAIL idle_rest got %h want %h",
               light, L_G0);
    else n_pass++;
    n_total++;
    if (dut.r_timer !== 4'd10)
      $display("FAIL idle_tsat got %0d want 10",
               dut.r_timer);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_gap_out();
    do_reset();
    run_to(4);
    req = 4'b0010;
    run_to(5);
    req = 4'b0000;
    if (pend !== 4'b0010)
      $display("FAIL gap_pend got %b want 0010", pend);
    else n_pass++;
    n_total++;
    run_to(23);
    if (light !== L_G0)
      $display("FAIL gap_g23 got %h want %h", light, L_G0);
    else n_pass++;
    n_total++;
    run_to(24);
    if (light !== L_Y0)
      $display("FAIL gap_y24 got %h want %h", light, L_Y0);
    else n_pass++;
    n_total++;
    run_to(35);
    if (light !== L_Y0)
      $display("FAIL gap_y35 got %h want %h", light, L_Y0);
    else n_pass++;
    n_total++;
    run_to(36);
    if (light !== L_RED)
      $display("FAIL gap_r36 got %h want %h", light, L_RED);
    else n_pass++;
    n_total++;
    run_to(39);
    if (light !== L_RED || pend !== 4'b0010)
      $display("FAIL gap_r39 got %h/%b want %h/0010",
               light, pend, L_RED);
    else n_pass++;
    n_total++;
    run_to(40);
    if (light !== L_G1 || grant_idx !== 2'd1)
      $display("FAIL gap_g40 got %h/%0d want %h/1",
               light, grant_idx, L_G1);
    else n_pass++;
    n_total++;
    if (pend !== 4'b0000)
      $display("FAIL gap_clr got %b want 0000", pend);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_round_robin();
    req = 4'b1001;
    run_to(41);
    req = 4'b0000;
    if (pend !== 4'b1001)
      $display("FAIL rr_pend got %b want 1001", pend);
    else n_pass++;
    n_total++;
    run_to(60);
    if (light !== L_Y1)
      $display("FAIL rr_y1 got %h want %h", light, L_Y1);
    else n_pass++;
    n_total++;
    run_to(72);
    if (light !== L_RED || pend !== 4'b1001)
      $display("FAIL rr_ar got %h/%b want %h/1001",
               light, pend, L_RED);
    else n_pass++;
    n_total++;
    run_to(76);
    if (light !== L_G3 || grant_idx !== 2'd3)
      $display("FAIL rr_g3 got %h/%0d want %h/3",
               light, grant_idx, L_G3);
    else n_pass++;
    n_total++;
    if (pend !== 4'b0001)
      $display("FAIL rr_p3 got %b want 0001", pend);
    else n_pass++;
    n_total++;
    run_to(96);
    if (light !== L_Y3)
      $display("FAIL rr_y3 got %h want %h", light, L_Y3);
    else n_pass++;
    n_total++;
    run_to(112);
    if (light !== L_G0 || grant_idx !== 2'd0 ||
        pend !== 4'b0000)
      $display("FAIL rr_g0 got %h/%0d/%b want %h/0/0000",
               light, grant_idx, pend, L_G0);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_max_out();
    do_reset();
    run_to(4);
    req = 4'b0101;
    run_to(43);
    if (light !== L_G0)
      $display("FAIL max_g43 got %h want %h", light, L_G0);
    else n_pass++;
    n_total++;
    run_to(44);
    if (light !== L_Y0)
      $display("FAIL max_y44 got %h want %h", light, L_Y0);
    else n_pass++;
    n_total++;
    run_to(60);
    req = 4'b0000;
    if (light !== L_G2 || grant_idx !== 2'd2)
      $display("FAIL max_g2 got %h/%0d want %h/2",
               light, grant_idx, L_G2);
    else n_pass++;
    n_total++;
    if (pend !== 4'b0001)
      $display("FAIL max_pend got %b want 0001", pend);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_async_reset();
    run_to(80);
    if (light !== L_Y2)
      $display("FAIL ar_y2 got %h want %h", light, L_Y2);
    else n_pass++;
    n_total++;
    run_to(82);
    rst_n = 1'b0;
    #1;
    if (light !== L_RED)
      $display("FAIL ar_light got %h want %h",
               light, L_RED);
    else n_pass++;
    n_total++;
    if (pend !== 4'b0 || grant_valid !== 1'b0 ||
        grant_idx !== 2'd0)
      $display("FAIL ar_state got %b/%b/%0d want 0/0/0",
               pend, grant_valid, grant_idx);
    else n_pass++;
    n_total++;
    @(negedge clk);
    rst_n = 1'b1;
    ecnt  = 0;
    run_to(3);
    if (light !== L_RED)
      $display("FAIL ar_c3 got %h want %h", light, L_RED);
    else n_pass++;
    n_total++;
    run_to(4);
    if (light !== L_G0 || grant_valid !== 1'b1)
      $display("FAIL ar_c4 got %h/%b want %h/1",
               light, grant_valid, L_G0);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_random();
    int         viol;
    logic [3:0] served;
    viol   = 0;
    served = '0;
    for (int i = 0; i < 1500; i++) begin
      req = 4'($urandom);
      @(posedge clk);
      #1;
      if (nonred(light) > 1) viol++;
      if (grant_valid) served[grant_idx] = 1'b1;
    end
    req = '0;
    if (viol != 0)
      $display("FAIL rnd_onegreen got %0d want 0", viol);
    else n_pass++;
    n_total++;
    if (served !== 4'b1111)
      $display("FAIL rnd_served got %b want 1111", served);
    else n_pass++;
    n_total++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    ecnt    = 0;
    rst_n   = 1'b0;
    req     = '0;
    test_reset();
    test_gap_out();
    test_round_robin();
    test_max_out();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/intersection_phase_scheduler.md
# intersection_phase_scheduler

- Sequences an N-approach signalised intersection: only one approach is green at a time.
- Latches per-approach vehicle-sensor requests and arbitrates them round-robin.
- Enforces minimum/maximum green, yellow and all-red clearance intervals, all counted in 1-second ticks from an internal prescaler.
- Sits between the road sensors and the lamp drivers; it replaces the fixed two-road highway/farm sequencing for multi-leg junctions.

## Interface
Parameters:
- N_APPROACH, 4 — number of approaches; must be ≥ 2.
- TICK_DIV, 4 — clk cycles per tick (4 for simulation, board value set at integration); must be ≥ 1.
- T_MIN_GREEN, 5 — minimum green, in ticks; must be ≥ 1.
- T_MAX_GREEN, 10 — maximum green when another approach is waiting; must be ≥ T_MIN_GREEN.
- T_YELLOW, 3 — yellow interval, in ticks; must be ≥ 1.
- T_ALL_RED, 1 — all-red clearance, in ticks; must be ≥ 1.

Ports:
- clk  in  1  — system clock; the block has one clock.
- rst_n  in  1  — asynchronous, active-low reset.
- req  in  N_APPROACH  — level vehicle sensors; bit i is approach i.
- light  out  3*N_APPROACH  — lamps for approach i at bits [3i+2:3i]; 100 = red, 010 = yellow, 001 = green.
- grant_idx  out  clog2(N_APPROACH)  — index of the current approach.
- grant_valid  out  1  — high while the current approach is green.
- pend  out  N_APPROACH  — latched pending requests, for status readout.

## Operation
- Reset values:
  - state = ALL_RED; cur = 0; timer = 0; pend = 0; prescaler count = 0.
  - light = all approaches 100; grant_idx = 0; grant_valid = 0.
- Tick:
  - Prescaler counts 0..TICK_DIV-1.
  - tick is high for exactly one cycle when count = TICK_DIV-1, then count wraps to 0.
  - First tick occurs in cycle TICK_DIV after reset release.
- Request latch:
  - pend[i] is set on any cycle where req[i] = 1, except when i = cur and state = GREEN.
  - pend[winner] is cleared on the edge that enters GREEN; clear takes priority over a simultaneous set.
- Arbitration (computed in ALL_RED):
  - winner = first set bit of pend, searching cur+1, cur+2, … mod N and wrapping through cur itself.
  - If pend = 0, winner = cur (green rests on the same approach).
- Timer:
  - timer counts completed ticks in the current state.
  - It is cleared on every state change and saturates at T_MAX_GREEN.
  - Below, "elapsed" means timer+1, evaluated on a tick cycle.
- State machine (all transitions happen only on tick cycles):
  - ALL_RED: when elapsed = T_ALL_RED, cur ← winner and go to GREEN.
  - GREEN: let other = |(pend with bit cur masked).
    - Go to YELLOW if other and (elapsed ≥ T_MAX_GREEN, or (elapsed ≥ T_MIN_GREEN and req[cur] = 0)).
    - Otherwise stay in GREEN; the state has no time limit when other = 0.
  - YELLOW: when elapsed = T_YELLOW, go to ALL_RED.
  - Any illegal state encoding goes to ALL_RED.
- Outputs are registered, Moore-style, and are updated on the same edge as state/cur:
  - Approach cur shows 001 in GREEN and 010 in YELLOW.
  - Every other approach, and every approach in ALL_RED, shows 100.
  - grant_idx = cur; grant_valid = (state == GREEN).
- Two approaches are never non-red at the same time; the bench checks this with an assertion.

## Timing
- Interval durations, with the tick period = TICK_DIV cycles:
  - YELLOW lasts exactly T_YELLOW ticks.
  - ALL_RED lasts exactly T_ALL_RED ticks.
  - GREEN lasts ≥ T_MIN_GREEN ticks, and ≤ T_MAX_GREEN ticks whenever another request is pending.
- States are entered on the tick edge, so every interval is aligned to the prescaler.
- Latency:
  - A req pulse of one cycle is captured in pend on the next edge.
  - That request is served within the sum over approaches of (T_MAX_GREEN + T_YELLOW + T_ALL_RED) ticks.
- Async reset: asserting rst_n mid-interval forces all reset values immediately, with no clock edge needed. After release the prescaler restarts from 0.

## Structure
- Shared package traffic_pkg:
  - Lamp constants LIGHT_RED = 3'b100, LIGHT_YEL = 3'b010, LIGHT_GRN = 3'b001.
  - Phase state enum {ALL_RED, GREEN, YELLOW}.
- One sub-module, tick_gen: the prescaler (parameter TICK_DIV; ports clk, rst_n, tick).
- Round-robin search is a combinational function inside the scheduler.
- Timer width is clog2(T_MAX_GREEN+1).

## Test plan
Defaults for all scenarios: N=4, TICK_DIV=4, T_MIN_GREEN=5, T_MAX_GREEN=10, T_YELLOW=3, T_ALL_RED=1.
- Reset/idle, req = 0:
  - All light = 100 through cycle 3.
  - At the cycle-4 tick, approach 0 turns 001 and grant_valid = 1.
  - Green rests there indefinitely; timer saturates at 10.
- Gap-out, approach 0 green, req[0] = 0, one-cycle pulse on req[1]:
  - pend[1] = 1 on the next edge.
  - Approach 0 stays green 5 ticks, then 010 for 3 ticks, then all 100 for 1 tick.
  - Approach 1 then turns 001 and pend[1] clears.
- Max-out, approach 0 green, req[0] and req[2] both held at 1:
  - Approach 0 stays green exactly 10 ticks, then yellow.
  - Next green is approach 2.
- Round-robin, cur = 1, pend = 4'b1001 at ALL_RED:
  - Approach 3 is served first, then approach 0.
- Async reset asserted mid-YELLOW on approach 2:
  - light goes to all 100, pend = 0 and grant_valid = 0 before the next clk edge.
  - After release, the cycle-4 tick grants approach 0.
- Throughout random req traffic: at most one approach is non-red in every cycle.
